tppe_correction_accumulator: RTL
================================

// Module: tppe_correction_accumulator
// PURPOSE
// - Parametrised successor to the single-entry correction stage of the TPPE.
// - Pseudo-accumulates fast_prefix matched weights over one output tile.
// - Applies a correction for every laggy_prefix entry, not just one: fetches the fibre-A spike word and subtracts the weight from each inactive timestep.
// - Emits TIMESTEPS corrected sums per tile over a valid/ready handshake, with saturation and an overflow flag.
// PARAMETERS
// - TIMESTEPS     8   timesteps per fibre-A word = result lanes
// - WEIGHT_WIDTH  8   unsigned weight width
// - PSEUDO_W      12  pseudo-accumulator width
// - CORR_W        12  per-lane correction accumulator width
// - RESULT_W      10  per-lane result width
// - POS_W         7   offset width (log2 of 128 fibre positions)
// - ADDR_WIDTH    8   fibre-A address width; offsets zero-extend to it
// - SATURATE      1   1: clamp results to [0, 2^RESULT_W-1]; 0: truncate
// PORTS
// - clk          in   1                    clock
// - rst          in   1                    reset, synchronous, active-high
// - fast_valid   in   1                    fast_prefix match valid
// - fast_weight  in   WEIGHT_WIDTH         matched weight
// - fast_last    in   1                    final fast beat of the tile
// - fast_ready   out  1                    fast beat accepted when valid&ready
// - slow_valid   in   1                    laggy_prefix entry valid (FIFO not empty)
// - slow_weight  in   WEIGHT_WIDTH         entry weight
// - slow_offset  in   POS_W                fibre-A offset
// - slow_last    in   1                    final slow entry of the tile
// - slow_ready   out  1                    pop strobe; entry consumed when valid&ready
// - slow_none    in   1                    tile has no slow entries; sampled with fast_last
// - fa_req       out  1                    fibre-A read request, one-cycle pulse
// - fa_addr      out  ADDR_WIDTH           fibre-A address, held until fa_rvalid
// - fa_rvalid    in   1                    read data valid; any latency >= 1
// - fa_rdata     in   TIMESTEPS            spike bits, bit t = timestep t active
// - res_valid    out  1                    tile results valid
// - res_ready    in   1                    downstream accepts results
// - res_data     out  TIMESTEPS*RESULT_W   lane t at [t*RESULT_W +: RESULT_W]
// - res_ovf      out  1                    some lane saturated or wrapped this tile
// BEHAVIOUR
// - Reset: all outputs 0 except fast_ready=1; state IDLE; pseudo, corr[], fast_done and slow_done cleared.
//   Reset mid-tile discards the tile; an outstanding fa_rvalid arriving after reset is ignored.
// - Fast path:
//   - fast_ready = (state != OUTPUT).
//   - On accept: pseudo <= pseudo + fast_weight, wrapping mod 2^PSEUDO_W; fast_last sets fast_done.
// - Correction FSM:
//   - IDLE:  slow_valid -> slow_ready=1 for one cycle; latch weight/offset; -> FETCH.
//   - FETCH: fa_req=1, fa_addr=offset -> WAIT.
//   - WAIT:  on fa_rvalid latch word -> APPLY.
//   - APPLY: corr[t] += w for every t with bit t == 0. All-ones word = no change.
//            Latched slow_last sets slow_done. -> IDLE.
//   - IDLE -> OUTPUT when fast_done && slow_done and no correction in flight.
//     slow_done is also set by slow_none sampled with the accepted fast_last beat.
//   - OUTPUT: registered res_valid=1.
//     Lane t = pseudo - corr[t], computed at max(PSEUDO_W, CORR_W)+1 bits signed.
//     SATURATE: negative -> 0 and ovf; > 2^RESULT_W-1 -> max and ovf.
//     res_data/res_ovf stable while valid && !ready.
//     On res_valid&&res_ready: clear pseudo, corr[], flags -> IDLE.
//     Next tile's fast beats stall meanwhile; slow entries stay in the FIFO.
// - Throughput: one slow entry per 4 cycles + memory latency. Fast path 1 beat/cycle, concurrent.
// - Simultaneous fast accept and APPLY in one cycle are independent; no interaction.
// - A fast beat accepted in the cycle OUTPUT is entered belongs to the current tile.
// - Latency: from the later of the last fast accept and the last APPLY to res_valid = 2 cycles.
// STRUCTURE
// - Shared package tppe_pkg: correction state encoding (IDLE/FETCH/WAIT/APPLY/OUTPUT)
//   and lane-width helper function; reused by laggy_prefix and fast_prefix.
// - Sub-module tppe_corr_lane (generate over TIMESTEPS):
//   - one corr register with clear, add-on-inactive-bit, and subtract/saturate output.
// - Top level holds pseudo accumulator, FSM, fibre-A interface and handshakes.
// TESTING
// - Fast 3,5,7 (last); one slow w=5, fa_rdata=8'b1010_1010 -> lanes even 10, odd 15; ovf=0.
// - Two slow entries w=4, words 8'hF0 then 8'h0F, pseudo=20
//   -> every lane 16 (each lane corrected once); second fetch issued only after first APPLY.
// - slow word 8'hFF -> all lanes = pseudo; slow_none with fast_last, no slow entries
//   -> res_valid 2 cycles after last fast accept.
// - SATURATE=1: pseudo=1500, RESULT_W=10 -> lanes 1023, res_ovf=1.
//   corr > pseudo -> lane 0, ovf=1.
// - res_ready held low 5 cycles -> res_data stable, fast_ready=0, slow_ready=0.
//   Release -> accumulators cleared; next tile starts from 0.
// - rst asserted in WAIT, then late fa_rvalid -> ignored.
//   All outputs at reset values; fresh tile yields uncorrupted results.

Source files
------------

// File: rtl/tppe_pkg.sv
// Shared TPPE definitions: correction-stage state encoding and the lane
// difference-width helper used when subtracting corrections from the pseudo sum.
package tppe_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_FETCH  = 3'd1,
    ST_WAIT   = 3'd2,
    ST_APPLY  = 3'd3,
    ST_OUTPUT = 3'd4
  } corr_state_e;

  // One extra bit over the wider operand so pseudo - corr never wraps.
  function automatic int lane_diff_w(input int a_w, input int b_w);
    return ((a_w > b_w) ? a_w : b_w) + 1;
  endfunction

endpackage

// File: rtl/tppe_corr_lane.sv
// One result lane: accumulates the correction for its timestep and produces
// the clamped (or truncated) pseudo - corr result with an overflow flag.
module tppe_corr_lane
  import tppe_pkg::*;
#(
  parameter int WEIGHT_WIDTH = 8,
  parameter int PSEUDO_W     = 12,
  parameter int CORR_W       = 12,
  parameter int RESULT_W     = 10,
  parameter int SATURATE     = 1
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    clr,
  input  logic                    add,
  input  logic [WEIGHT_WIDTH-1:0] weight,
  input  logic [PSEUDO_W-1:0]     pseudo,
  output logic [RESULT_W-1:0]     res,
  output logic                    ovf
);

  localparam int DW = lane_diff_w(PSEUDO_W, CORR_W);

  logic [CORR_W-1:0]   corr;
  logic [DW-1:0]       diff;
  logic [RESULT_W-1:0] lo;
  logic                neg;
  logic                hi;

  always_ff @(posedge clk) begin
    if (rst || clr)
      corr <= '0;
    else if (add)
      corr <= corr + CORR_W'(weight);
  end

  assign diff = DW'(pseudo) - DW'(corr);
  assign neg  = diff[DW-1];

  // Upper-range overflow is only possible when the result is narrower than the difference.
  if (RESULT_W >= DW - 1) begin : g_nohi
    assign hi = 1'b0;
    assign lo = RESULT_W'($signed(diff));
  end else begin : g_hi
    assign hi = ~neg & (|diff[DW-2:RESULT_W]);
    assign lo = diff[RESULT_W-1:0];
  end

  always_comb begin
    res = lo;
    ovf = neg | hi;
    if (SATURATE != 0) begin
      if (neg)
        res = '0;
      else if (hi)
        res = '1;
    end
  end

endmodule

// File: rtl/tppe_correction_accumulator.sv
// Tile accumulator: sums fast_prefix weights, corrects every laggy_prefix entry
// against its fibre-A spike word, and hands out TIMESTEPS lane results per tile.
module tppe_correction_accumulator
  import tppe_pkg::*;
#(
  parameter int TIMESTEPS    = 8,
  parameter int WEIGHT_WIDTH = 8,
  parameter int PSEUDO_W     = 12,
  parameter int CORR_W       = 12,
  parameter int RESULT_W     = 10,
  parameter int POS_W        = 7,
  parameter int ADDR_WIDTH   = 8,
  parameter int SATURATE     = 1
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic                            fast_valid,
  input  logic [WEIGHT_WIDTH-1:0]         fast_weight,
  input  logic                            fast_last,
  output logic                            fast_ready,
  input  logic                            slow_valid,
  input  logic [WEIGHT_WIDTH-1:0]         slow_weight,
  input  logic [POS_W-1:0]                slow_offset,
  input  logic                            slow_last,
  output logic                            slow_ready,
  input  logic                            slow_none,
  output logic                            fa_req,
  output logic [ADDR_WIDTH-1:0]           fa_addr,
  input  logic                            fa_rvalid,
  input  logic [TIMESTEPS-1:0]            fa_rdata,
  output logic                            res_valid,
  input  logic                            res_ready,
  output logic [TIMESTEPS*RESULT_W-1:0]   res_data,
  output logic                            res_ovf
);

  corr_state_e state, state_nx;

  logic [PSEUDO_W-1:0]     pseudo;
  logic                    fast_done;
  logic                    slow_done;
  logic [WEIGHT_WIDTH-1:0] w_q;
  logic [POS_W-1:0]        off_q;
  logic                    last_q;
  logic [TIMESTEPS-1:0]    word_q;
  logic                    fast_acc;
  logic                    slow_acc;
  logic                    res_hs;
  logic                    apply;

  logic [TIMESTEPS-1:0][RESULT_W-1:0] lane_res;
  logic [TIMESTEPS-1:0]               lane_ovf;

  always_ff @(posedge clk) begin
    if (rst)
      state <= ST_IDLE;
    else
      state <= state_nx;
  end

  // Tile completion wins over a pending slow entry: that entry belongs to the next tile.
  always_comb begin
    state_nx = state;
    case (state)
      ST_IDLE: begin
        if (fast_done && slow_done)
          state_nx = ST_OUTPUT;
        else if (slow_valid && !slow_done)
          state_nx = ST_FETCH;
      end
      ST_FETCH:  state_nx = ST_WAIT;
      ST_WAIT:   if (fa_rvalid) state_nx = ST_APPLY;
      ST_APPLY:  state_nx = ST_IDLE;
      ST_OUTPUT: if (res_ready) state_nx = ST_IDLE;
      default:   state_nx = ST_IDLE;
    endcase
  end

  always_comb begin
    fast_ready = (state != ST_OUTPUT);
    slow_ready = (state == ST_IDLE) && slow_valid && !slow_done;
    fa_req     = (state == ST_FETCH);
    res_valid  = (state == ST_OUTPUT);
  end

  assign fast_acc = fast_valid & fast_ready;
  assign slow_acc = slow_valid & slow_ready;
  assign res_hs   = res_valid & res_ready;
  assign apply    = (state == ST_APPLY);

  always_ff @(posedge clk) begin
    if (rst || res_hs) begin
      pseudo    <= '0;
      fast_done <= 1'b0;
      slow_done <= 1'b0;
    end else begin
      if (fast_acc) begin
        pseudo <= pseudo + PSEUDO_W'(fast_weight);
        if (fast_last) begin
          fast_done <= 1'b1;
          if (slow_none)
            slow_done <= 1'b1;
        end
      end
      if (apply && last_q)
        slow_done <= 1'b1;
    end
  end

  // Read data is only taken in WAIT, so a response left over from before reset is dropped.
  always_ff @(posedge clk) begin
    if (rst) begin
      w_q    <= '0;
      off_q  <= '0;
      last_q <= 1'b0;
      word_q <= '0;
    end else begin
      if (slow_acc) begin
        w_q    <= slow_weight;
        off_q  <= slow_offset;
        last_q <= slow_last;
      end
      if ((state == ST_WAIT) && fa_rvalid)
        word_q <= fa_rdata;
    end
  end

  assign fa_addr = ADDR_WIDTH'(off_q);

  for (genvar t = 0; t < TIMESTEPS; t++) begin : g_lane
    tppe_corr_lane #(
      .WEIGHT_WIDTH (WEIGHT_WIDTH),
      .PSEUDO_W     (PSEUDO_W),
      .CORR_W       (CORR_W),
      .RESULT_W     (RESULT_W),
      .SATURATE     (SATURATE)
    ) u_lane (
      .clk    (clk),
      .rst    (rst),
      .clr    (res_hs),
      .add    (apply && !word_q[t]),
      .weight (w_q),
      .pseudo (pseudo),
      .res    (lane_res[t]),
      .ovf    (lane_ovf[t])
    );
  end

  assign res_data = res_valid ? lane_res : '0;
  assign res_ovf  = res_valid & (|lane_ovf);

endmodule
